// File: rtl/case_9_accum_pkg.sv
// Shared types, default widths and rail helpers for the case_9 accumulator stages.
package case_9_accum_pkg;

    localparam int unsigned PROD_WIDTH_DEF = 14;
    localparam int unsigned ACC_WIDTH_DEF  = 20;
    localparam int unsigned LEN_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    function automatic logic signed [31:0] acc_max(input int unsigned w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] acc_min(input int unsigned w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/case_9_sat_add.sv
// Combinational saturating add of a sign-extended product into an accumulator.
module case_9_sat_add
    import case_9_accum_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic signed [PROD_WIDTH-1:0] prod,
    output logic signed [ACC_WIDTH-1:0]  sum,
    output logic                         clamped
);

    localparam logic signed [ACC_WIDTH-1:0] AccMax = ACC_WIDTH'(acc_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] AccMin = ACC_WIDTH'(acc_min(ACC_WIDTH));

    logic [ACC_WIDTH:0] w_wide;

    assign w_wide = {acc[ACC_WIDTH-1], acc}
                  + {{(ACC_WIDTH + 1 - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

    // Top two bits disagree only when the true sum left the ACC_WIDTH range.
    assign clamped = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];

    always_comb begin
        sum = w_wide[ACC_WIDTH-1:0];
        if (clamped) begin
            sum = w_wide[ACC_WIDTH] ? AccMin : AccMax;
        end
    end

endmodule

// File: rtl/case_9_prod_accum.sv
// Frame accumulator: sums len signed products with saturation, holds result until acked.
module case_9_prod_accum
    import case_9_accum_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_start,
    input  logic [LEN_WIDTH-1:0]         len,
    output logic                         ap_idle,
    output logic                         ap_done,
    input  logic signed [PROD_WIDTH-1:0] prod_dout,
    input  logic                         prod_vld,
    output logic                         prod_ack,
    output logic signed [ACC_WIDTH-1:0]  sum_dout,
    output logic                         sum_vld,
    input  logic                         sum_ack,
    output logic                         ovf
);

    state_e                       r_state;
    logic [LEN_WIDTH-1:0]         r_remaining;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_ovf;

    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic                         w_clamped;

    case_9_sat_add #(
        .PROD_WIDTH (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat_add (
        .acc     (r_acc),
        .prod    (prod_dout),
        .sum     (w_sum),
        .clamped (w_clamped)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (ap_start) begin
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_remaining <= len;
                        r_state     <= (len == '0) ? StHold : StAccum;
                    end
                end
                StAccum: begin
                    if (prod_vld) begin
                        r_acc       <= w_sum;
                        r_ovf       <= r_ovf | w_clamped;
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_state <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (sum_ack) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // acc and ovf only change in StIdle/StAccum, so they are stable across StHold.
    assign ap_idle  = (r_state == StIdle);
    assign prod_ack = (r_state == StAccum);
    assign sum_vld  = (r_state == StHold);
    assign ap_done  = (r_state == StHold) && sum_ack;
    assign sum_dout = r_acc;
    assign ovf      = r_ovf;

endmodule
